// File: rtl/hci_package.sv
// Shared types and limits for the HCI bank adapters.
package hci_package;

  localparam int HCI_BANK_MAX_LAT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    TS_WR = 1'b1
  } hci_bank_ts_state_e;

endpackage

// File: rtl/hci_bank_resp_pipe.sv
// Response shift register for one bank: {valid, read flag, id} delayed by MEM_LAT
// cycles so each response lines up with the SRAM read data. clear_i drops all in-flight entries.
module hci_bank_resp_pipe #(
  parameter int MEM_LAT = 1,
  parameter int IW      = 20
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          valid_i,
  input  logic          read_i,
  input  logic [IW-1:0] id_i,
  output logic          valid_o,
  output logic          read_o,
  output logic [IW-1:0] id_o
);

  logic [MEM_LAT-1:0] valid_q, valid_d;
  logic [MEM_LAT-1:0] read_q, read_d;
  logic [IW-1:0]      id_q [MEM_LAT];
  logic [IW-1:0]      id_d [MEM_LAT];

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    read_d  = read_q;
    id_d    = id_q;
    valid_d[0] = valid_i;
    read_d[0]  = read_i;
    id_d[0]    = id_i;
    for (int i = 1; i < MEM_LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      read_d[i]  = read_q[i-1];
      id_d[i]    = id_q[i-1];
    end
    // Flushing the valids is enough; stale ids and read flags are never observed.
    if (clear_i) begin
      valid_d = '0;
      read_d  = '0;
    end
  end

  // NOTE: state uses non-blocking assignments so all stages shift on the same edge.
  // NOTE: the id stages are flops, not RAM, and are reset so r_id_o is '0 out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      read_q  <= '0;
      for (int i = 0; i < MEM_LAT; i++) id_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      read_q  <= read_d;
      id_q    <= id_d;
    end
  end

  assign valid_o = valid_q[MEM_LAT-1];
  assign read_o  = read_q[MEM_LAT-1];
  assign id_o    = id_q[MEM_LAT-1];

endmodule

// File: rtl/hci_bank_ts_adapter.sv
// HCI log-interconnect target port to single-port SRAM bank, with MEM_LAT-aligned responses.
// Define HCI_BANK_TS_EN to compile in the atomic test-and-set (read old value, then write all ones).
module hci_bank_ts_adapter
  import hci_package::*;
#(
  parameter int AW      = 12,
  parameter int DW      = 32,
  parameter int BW      = 8,
  parameter int IW      = 20,
  parameter int MEM_LAT = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             req_i,
  output logic             gnt_o,
  input  logic [AW-1:0]    add_i,
  input  logic             wen_i,
  input  logic [DW-1:0]    data_i,
  input  logic [DW/BW-1:0] be_i,
  input  logic [IW-1:0]    id_i,
  input  logic             ts_set_i,
  output logic             r_valid_o,
  output logic [DW-1:0]    r_data_o,
  output logic [IW-1:0]    r_id_o,
  output logic             mem_req_o,
  output logic             mem_wen_o,
  output logic [AW-1:0]    mem_add_o,
  output logic [DW-1:0]    mem_wdata_o,
  output logic [DW/BW-1:0] mem_be_o,
  input  logic [DW-1:0]    mem_rdata_i
);

  if (MEM_LAT < 1 || MEM_LAT > HCI_BANK_MAX_LAT) begin : g_lat_check
    $error("hci_bank_ts_adapter: MEM_LAT must be within 1..HCI_BANK_MAX_LAT");
  end

  logic granted;
  logic resp_read;

`ifdef HCI_BANK_TS_EN
  hci_bank_ts_state_e state_q;
  logic [AW-1:0]      ts_add_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ts_add_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i && ts_set_i && wen_i && !clear_i) begin
            state_q  <= TS_WR;
            ts_add_q <= add_i;
          end
        end
        TS_WR:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o = (state_q == IDLE);

  // The lock write owns the bank for one cycle; otherwise the request passes straight through.
  always_comb begin
    mem_req_o   = req_i;
    mem_wen_o   = wen_i;
    mem_add_o   = add_i;
    mem_wdata_o = data_i;
    mem_be_o    = be_i;
    if (state_q == TS_WR) begin
      mem_req_o   = 1'b1;
      mem_wen_o   = 1'b0;
      mem_add_o   = ts_add_q;
      mem_wdata_o = '1;
      mem_be_o    = '1;
    end
  end
`else
  logic unused_ts_set;
  assign unused_ts_set = ts_set_i;

  assign gnt_o       = 1'b1;
  assign mem_req_o   = req_i;
  assign mem_wen_o   = wen_i;
  assign mem_add_o   = add_i;
  assign mem_wdata_o = data_i;
  assign mem_be_o    = be_i;
`endif

  assign granted = req_i & gnt_o;

  hci_bank_resp_pipe #(
    .MEM_LAT (MEM_LAT),
    .IW      (IW)
  ) i_resp_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .valid_i (granted),
    .read_i  (wen_i),
    .id_i    (id_i),
    .valid_o (r_valid_o),
    .read_o  (resp_read),
    .id_o    (r_id_o)
  );

  assign r_data_o = (r_valid_o && resp_read) ? mem_rdata_i : '0;

endmodule
